// File: rtl/membus_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// eei : shared architectural constants for the core's memory bus.
//   XLEN              - address width of every Membus port
//   MEMBUS_DATA_WIDTH - data width of every Membus port (wmask is 1 bit/byte)
//   MembusOwner       - which requester an outstanding Membus transaction
//                       belongs to (NONE, INST = fetch, DATA = load/store)
// -----------------------------------------------------------------------------
package eei;

   localparam int unsigned XLEN              = 32;
   localparam int unsigned MEMBUS_DATA_WIDTH = 32;

   typedef enum logic [1:0] {
      NONE = 2'd0,
      INST = 2'd1,
      DATA = 2'd2
   } MembusOwner;

endpackage

// File: rtl/membus_arbiter_if.sv
// -----------------------------------------------------------------------------
// Membus : valid/ready request channel plus rvalid response channel.
//   valid  - request present (master -> slave)
//   ready  - request accepted this cycle when valid is also 1 (slave -> master)
//   addr   - byte address, XLEN bits
//   wen    - 1 = write, 0 = read
//   wdata  - write data
//   wmask  - byte enables for wdata
//   rvalid - response present (slave -> master)
//   rdata  - read data, qualified by rvalid
// -----------------------------------------------------------------------------
interface Membus;
   import eei::*;

   logic                           valid;
   logic                           ready;
   logic [XLEN-1:0]                addr;
   logic                           wen;
   logic [MEMBUS_DATA_WIDTH-1:0]   wdata;
   logic [MEMBUS_DATA_WIDTH/8-1:0] wmask;
   logic                           rvalid;
   logic [MEMBUS_DATA_WIDTH-1:0]   rdata;

   modport master (
      output valid, addr, wen, wdata, wmask,
      input  ready, rvalid, rdata
   );

   modport slave (
      input  valid, addr, wen, wdata, wmask,
      output ready, rvalid, rdata
   );

endinterface

// File: rtl/membus_arbiter_chk.sv
// -----------------------------------------------------------------------------
// membus_arbiter_chk : simulation-only observer for membus_arbiter.
//   clk      - clock
//   rst      - synchronous active-high reset
//   rvalid_i - downstream membus.rvalid
//   owner_i  - arbiter's registered owner state
// Warns when a downstream response arrives with no outstanding owner; the
// arbiter drops such a response, so this is the only place it is visible.
// -----------------------------------------------------------------------------
module membus_arbiter_chk
   import eei::*;
#(
   parameter int unsigned STARVE_LIMIT = 8
) (
   input logic       clk,
   input logic       rst,
   input logic       rvalid_i,
   input MembusOwner owner_i
);

`ifndef SYNTHESIS
   localparam bit LIMIT_OK = (STARVE_LIMIT >= 32'd1);

   // Parameter sanity and stray-response detection, outside reset only.
   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (LIMIT_OK)
            else $error("membus_arbiter: STARVE_LIMIT must be at least 1");
         assert (!(rvalid_i && (owner_i == NONE)))
            else $warning("membus_arbiter: stray rvalid dropped, no outstanding owner");
      end
   end
`endif

endmodule

// File: rtl/membus_arbiter.sv
// -----------------------------------------------------------------------------
// membus_arbiter : shares one downstream Membus master port between the
// instruction-fetch and load/store requesters.
//   clk      - clock, all state on posedge
//   rst      - synchronous active-high reset
//   i_membus - Membus.slave, instruction-fetch requester
//   d_membus - Membus.slave, load/store requester
//   membus   - Membus.master, downstream port toward mmio_controller
// Fixed data-over-instruction priority with combinational request and
// response paths. A single registered owner tracks the one outstanding
// transaction so its response can be routed back.
// Optional feature: define MEMBUS_ARB_STARVE_GUARD_EN to compile in the
// fetch starvation guard, which forces a fetch grant after STARVE_LIMIT
// consecutive data acceptances while a fetch was pending.
// -----------------------------------------------------------------------------
module membus_arbiter
   import eei::*;
#(
   parameter int unsigned STARVE_LIMIT = 8
) (
   input logic   clk,
   input logic   rst,
   Membus.slave  i_membus,
   Membus.slave  d_membus,
   Membus.master membus
);

   MembusOwner owner_q;
   MembusOwner owner_d;

   logic grant_data;
   logic grant_inst;
   logic force_inst;
   logic accept;

`ifdef MEMBUS_ARB_STARVE_GUARD_EN
   localparam int unsigned      CNT_W      = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

   logic [CNT_W-1:0] starve_cnt_q;
   logic [CNT_W-1:0] starve_cnt_d;

   // A saturated counter only forces fetch while fetch is still asking.
   always_comb begin
      force_inst = (starve_cnt_q == STARVE_MAX) && i_membus.valid;
   end

   // Count data acceptances that overtook a pending fetch.
   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (!i_membus.valid || (accept && grant_inst)) begin
         starve_cnt_d = '0;
      end else if (accept && grant_data && (starve_cnt_q != STARVE_MAX)) begin
         starve_cnt_d = starve_cnt_q + CNT_W'(1'b1);
      end else begin
         starve_cnt_d = starve_cnt_q;
      end
   end

   // Starvation counter register.
   always_ff @(posedge clk) begin
      if (rst) begin
         starve_cnt_q <= '0;
      end else begin
         starve_cnt_q <= starve_cnt_d;
      end
   end
`else
   // Pure data-first priority; fetch may starve.
   always_comb begin
      force_inst = 1'b0;
   end
`endif

   // Grant selection; reset blocks both grants so nothing leaks downstream.
   always_comb begin
      grant_data = !rst && d_membus.valid && !force_inst;
      grant_inst = !rst && i_membus.valid && !grant_data;
   end

   // Downstream request mux; zeros when nobody is granted.
   always_comb begin
      membus.valid = 1'b0;
      membus.addr  = '0;
      membus.wen   = 1'b0;
      membus.wdata = '0;
      membus.wmask = '0;
      if (grant_data) begin
         membus.valid = d_membus.valid;
         membus.addr  = d_membus.addr;
         membus.wen   = d_membus.wen;
         membus.wdata = d_membus.wdata;
         membus.wmask = d_membus.wmask;
      end else if (grant_inst) begin
         membus.valid = i_membus.valid;
         membus.addr  = i_membus.addr;
         membus.wen   = i_membus.wen;
         membus.wdata = i_membus.wdata;
         membus.wmask = i_membus.wmask;
      end else begin
         membus.valid = 1'b0;
      end
   end

   // Ready goes back only to the granted side; grants already fold in rst.
   always_comb begin
      i_membus.ready = membus.ready && grant_inst;
      d_membus.ready = membus.ready && grant_data;
      accept         = membus.valid && membus.ready;
   end

   // Response routing by owner; unowned (stray) responses reach nobody.
   always_comb begin
      i_membus.rvalid = 1'b0;
      d_membus.rvalid = 1'b0;
      i_membus.rdata  = '0;
      d_membus.rdata  = '0;
      if (!rst && (owner_q == INST)) begin
         i_membus.rvalid = membus.rvalid;
         i_membus.rdata  = membus.rdata;
      end else if (!rst && (owner_q == DATA)) begin
         d_membus.rvalid = membus.rvalid;
         d_membus.rdata  = membus.rdata;
      end else begin
         i_membus.rvalid = 1'b0;
      end
   end

   // Owner next state; a new acceptance wins over completion (back-to-back).
   always_comb begin
      owner_d = owner_q;
      if (accept && grant_data) begin
         owner_d = DATA;
      end else if (accept && grant_inst) begin
         owner_d = INST;
      end else if (membus.rvalid) begin
         owner_d = NONE;
      end else begin
         owner_d = owner_q;
      end
   end

   // Owner register; reset discards any outstanding transaction.
   always_ff @(posedge clk) begin
      if (rst) begin
         owner_q <= NONE;
      end else begin
         owner_q <= owner_d;
      end
   end

`ifndef SYNTHESIS
   membus_arbiter_chk #(
      .STARVE_LIMIT (STARVE_LIMIT)
   ) u_chk (
      .clk      (clk),
      .rst      (rst),
      .rvalid_i (membus.rvalid),
      .owner_i  (owner_q)
   );
`endif

endmodule

// File: tb/tb_membus_arbiter.sv
module tb_membus_arbiter;
   import eei::*;

   typedef struct {
      MembusOwner  port;
      logic [31:0] data;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   exp_t sb_q[$];

   always #5 clk = ~clk;

   Membus i_bus ();
   Membus d_bus ();
   Membus m_bus ();

   membus_arbiter #(
      .STARVE_LIMIT (4)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .i_membus (i_bus),
      .d_membus (d_bus),
      .membus   (m_bus)
   );

   task automatic drive_idle();
      i_bus.valid = 1'b0; i_bus.addr = 32'h0; i_bus.wen = 1'b0; i_bus.wdata = 32'h0; i_bus.wmask = 4'h0;
      d_bus.valid = 1'b0; d_bus.addr = 32'h0; d_bus.wen = 1'b0; d_bus.wdata = 32'h0; d_bus.wmask = 4'h0;
      m_bus.ready = 1'b1; m_bus.rvalid = 1'b0; m_bus.rdata = 32'h0;
   endtask

   task automatic test_reset();
      drive_idle();
      rst = 1'b1;
      i_bus.valid = 1'b1; i_bus.addr = 32'h0000_1234;
      d_bus.valid = 1'b1; d_bus.addr = 32'h0000_5678; d_bus.wen = 1'b1; d_bus.wdata = 32'hFFFF_FFFF;
      m_bus.rvalid = 1'b1; m_bus.rdata = 32'hFFFF_FFFF;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({i_bus.ready, d_bus.ready, i_bus.rvalid, d_bus.rvalid, m_bus.valid} !== 5'b0) begin
         errors++;
         $display("FAIL reset_ctrl: got %b expected 00000", {i_bus.ready, d_bus.ready, i_bus.rvalid, d_bus.rvalid, m_bus.valid});
      end
      checks++;
      if ({i_bus.rdata, d_bus.rdata} !== 64'h0) begin
         errors++;
         $display("FAIL reset_rdata: got %h expected 0", {i_bus.rdata, d_bus.rdata});
      end
      checks++;
      if ({m_bus.addr, m_bus.wen, m_bus.wdata, m_bus.wmask} !== 69'h0) begin
         errors++;
         $display("FAIL reset_req: got %h expected 0", {m_bus.addr, m_bus.wen, m_bus.wdata, m_bus.wmask});
      end
      @(posedge clk); #1;
      rst = 1'b0;
      drive_idle();
   endtask

   task automatic test_single_fetch();
      exp_t        e;
      logic [65:0] ev;
      @(posedge clk); #1;
      i_bus.valid = 1'b1; i_bus.addr = 32'h8000_0000;
      @(negedge clk);
      checks++;
      if ({m_bus.valid, m_bus.addr, i_bus.ready, d_bus.ready} !== {1'b1, 32'h8000_0000, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL fetch_req: got %h expected %h", {m_bus.valid, m_bus.addr, i_bus.ready, d_bus.ready}, {1'b1, 32'h8000_0000, 1'b1, 1'b0});
      end
      sb_q.push_back('{INST, 32'h0000_0013});
      @(posedge clk); #1;
      i_bus.valid = 1'b0; m_bus.ready = 1'b0;
      @(posedge clk); #1;
      m_bus.rvalid = 1'b1; m_bus.rdata = 32'h0000_0013; m_bus.ready = 1'b1;
      @(negedge clk);
      e  = sb_q.pop_front();
      ev = {e.port == INST, e.port == DATA, (e.port == INST) ? e.data : 32'h0, (e.port == DATA) ? e.data : 32'h0};
      checks++;
      if ({i_bus.rvalid, d_bus.rvalid, i_bus.rdata, d_bus.rdata} !== ev) begin
         errors++;
         $display("FAIL fetch_resp: got %h expected %h", {i_bus.rvalid, d_bus.rvalid, i_bus.rdata, d_bus.rdata}, ev);
      end
      @(posedge clk); #1;
      drive_idle();
   endtask

   task automatic test_back_to_back();
      exp_t        e;
      logic [65:0] ev;
      @(posedge clk); #1;
      i_bus.valid = 1'b1; i_bus.addr = 32'h8000_0004;
      d_bus.valid = 1'b1; d_bus.addr = 32'h8000_1000; d_bus.wen = 1'b1; d_bus.wdata = 32'h0000_CAFE; d_bus.wmask = 4'hF;
      @(negedge clk);
      checks++;
      if ({m_bus.valid, m_bus.addr, m_bus.wen, m_bus.wdata, m_bus.wmask, d_bus.ready, i_bus.ready} !==
          {1'b1, 32'h8000_1000, 1'b1, 32'h0000_CAFE, 4'hF, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL simul_req: got %h expected %h", {m_bus.valid, m_bus.addr, m_bus.wen, m_bus.wdata, m_bus.wmask, d_bus.ready, i_bus.ready},
                  {1'b1, 32'h8000_1000, 1'b1, 32'h0000_CAFE, 4'hF, 1'b1, 1'b0});
      end
      sb_q.push_back('{DATA, 32'h0000_1111});
      @(posedge clk); #1;
      d_bus.valid = 1'b0; d_bus.wen = 1'b0; m_bus.ready = 1'b0;
      @(posedge clk); #1;
      m_bus.ready = 1'b1; m_bus.rvalid = 1'b1; m_bus.rdata = 32'h0000_1111;
      @(negedge clk);
      e  = sb_q.pop_front();
      ev = {e.port == INST, e.port == DATA, (e.port == INST) ? e.data : 32'h0, (e.port == DATA) ? e.data : 32'h0};
      checks++;
      if ({i_bus.rvalid, d_bus.rvalid, i_bus.rdata, d_bus.rdata} !== ev) begin
         errors++;
         $display("FAIL b2b_data_resp: got %h expected %h", {i_bus.rvalid, d_bus.rvalid, i_bus.rdata, d_bus.rdata}, ev);
      end
      checks++;
      if ({i_bus.ready, m_bus.valid, m_bus.addr, m_bus.wen} !== {1'b1, 1'b1, 32'h8000_0004, 1'b0}) begin
         errors++;
         $display("FAIL b2b_inst_req: got %h expected %h", {i_bus.ready, m_bus.valid, m_bus.addr, m_bus.wen}, {1'b1, 1'b1, 32'h8000_0004, 1'b0});
      end
      sb_q.push_back('{INST, 32'h0000_2222});
      @(posedge clk); #1;
      i_bus.valid = 1'b0; m_bus.ready = 1'b0; m_bus.rvalid = 1'b0;
      @(posedge clk); #1;
      m_bus.ready = 1'b1; m_bus.rvalid = 1'b1; m_bus.rdata = 32'h0000_2222;
      @(negedge clk);
      e  = sb_q.pop_front();
      ev = {e.port == INST, e.port == DATA, (e.port == INST) ? e.data : 32'h0, (e.port == DATA) ? e.data : 32'h0};
      checks++;
      if ({i_bus.rvalid, d_bus.rvalid, i_bus.rdata, d_bus.rdata} !== ev) begin
         errors++;
         $display("FAIL b2b_inst_resp: got %h expected %h", {i_bus.rvalid, d_bus.rvalid, i_bus.rdata, d_bus.rdata}, ev);
      end
      @(posedge clk); #1;
      drive_idle();
   endtask

   task automatic test_busy();
      exp_t        e;
      logic [65:0] ev;
      @(posedge clk); #1;
      d_bus.valid = 1'b1; d_bus.addr = 32'h8000_2000; m_bus.ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checks++;
         if ({d_bus.ready, i_bus.ready, m_bus.valid, m_bus.addr} !== {1'b0, 1'b0, 1'b1, 32'h8000_2000}) begin
            errors++;
            $display("FAIL busy_hold%0d: got %h expected %h", c, {d_bus.ready, i_bus.ready, m_bus.valid, m_bus.addr}, {1'b0, 1'b0, 1'b1, 32'h8000_2000});
         end
         @(posedge clk); #1;
      end
      m_bus.ready = 1'b1;
      @(negedge clk);
      checks++;
      if (d_bus.ready !== 1'b1) begin
         errors++;
         $display("FAIL busy_accept: got %b expected 1", d_bus.ready);
      end
      sb_q.push_back('{DATA, 32'h0000_3333});
      @(posedge clk); #1;
      d_bus.valid = 1'b0; m_bus.rvalid = 1'b1; m_bus.rdata = 32'h0000_3333;
      @(negedge clk);
      e  = sb_q.pop_front();
      ev = {e.port == INST, e.port == DATA, (e.port == INST) ? e.data : 32'h0, (e.port == DATA) ? e.data : 32'h0};
      checks++;
      if ({i_bus.rvalid, d_bus.rvalid, i_bus.rdata, d_bus.rdata} !== ev) begin
         errors++;
         $display("FAIL busy_resp: got %h expected %h", {i_bus.rvalid, d_bus.rvalid, i_bus.rdata, d_bus.rdata}, ev);
      end
      // A second response must find no owner: the request was accepted once.
      sb_q.push_back('{NONE, 32'h0000_4444});
      @(posedge clk); #1;
      m_bus.rdata = 32'h0000_4444;
      @(negedge clk);
      e  = sb_q.pop_front();
      ev = {e.port == INST, e.port == DATA, (e.port == INST) ? e.data : 32'h0, (e.port == DATA) ? e.data : 32'h0};
      checks++;
      if ({i_bus.rvalid, d_bus.rvalid, i_bus.rdata, d_bus.rdata} !== ev) begin
         errors++;
         $display("FAIL busy_once: got %h expected %h", {i_bus.rvalid, d_bus.rvalid, i_bus.rdata, d_bus.rdata}, ev);
      end
      @(posedge clk); #1;
      drive_idle();
   endtask

   task automatic test_stray();
      exp_t        e;
      logic [65:0] ev;
      @(posedge clk); #1;
      m_bus.rvalid = 1'b1; m_bus.rdata = 32'h0000_DEAD;
      sb_q.push_back('{NONE, 32'h0000_DEAD});
      @(negedge clk);
      e  = sb_q.pop_front();
      ev = {e.port == INST, e.port == DATA, (e.port == INST) ? e.data : 32'h0, (e.port == DATA) ? e.data : 32'h0};
      checks++;
      if ({i_bus.rvalid, d_bus.rvalid, i_bus.rdata, d_bus.rdata} !== ev) begin
         errors++;
         $display("FAIL stray_resp: got %h expected %h", {i_bus.rvalid, d_bus.rvalid, i_bus.rdata, d_bus.rdata}, ev);
      end
      @(posedge clk); #1;
      drive_idle();
   endtask

   task automatic test_starve();
      exp_t        e;
      logic [65:0] ev;
      logic        exp_inst;
      @(posedge clk); #1;
      i_bus.valid = 1'b1; i_bus.addr = 32'h8000_0010;
      d_bus.valid = 1'b1; d_bus.addr = 32'h8000_4000;
      for (int n = 1; n <= 6; n++) begin
         m_bus.rvalid = (n > 1);
         m_bus.rdata  = 32'h0000_0100 + 32'(n);
`ifdef MEMBUS_ARB_STARVE_GUARD_EN
         exp_inst = (n == 5);
`else
         exp_inst = 1'b0;
`endif
         @(negedge clk);
         if (n > 1) begin
            e  = sb_q.pop_front();
            ev = {e.port == INST, e.port == DATA, (e.port == INST) ? e.data : 32'h0, (e.port == DATA) ? e.data : 32'h0};
            checks++;
            if ({i_bus.rvalid, d_bus.rvalid, i_bus.rdata, d_bus.rdata} !== ev) begin
               errors++;
               $display("FAIL starve_resp%0d: got %h expected %h", n, {i_bus.rvalid, d_bus.rvalid, i_bus.rdata, d_bus.rdata}, ev);
            end
         end
         checks++;
         if ({i_bus.ready, d_bus.ready} !== {exp_inst, !exp_inst}) begin
            errors++;
            $display("FAIL starve_grant%0d: got %b expected %b", n, {i_bus.ready, d_bus.ready}, {exp_inst, !exp_inst});
         end
         sb_q.push_back('{exp_inst ? INST : DATA, 32'h0000_0100 + 32'(n + 1)});
         @(posedge clk); #1;
      end
      i_bus.valid = 1'b0; d_bus.valid = 1'b0;
      m_bus.rvalid = 1'b1; m_bus.rdata = 32'h0000_0107;
      @(negedge clk);
      e  = sb_q.pop_front();
      ev = {e.port == INST, e.port == DATA, (e.port == INST) ? e.data : 32'h0, (e.port == DATA) ? e.data : 32'h0};
      checks++;
      if ({i_bus.rvalid, d_bus.rvalid, i_bus.rdata, d_bus.rdata} !== ev) begin
         errors++;
         $display("FAIL starve_last: got %h expected %h", {i_bus.rvalid, d_bus.rvalid, i_bus.rdata, d_bus.rdata}, ev);
      end
      @(posedge clk); #1;
      drive_idle();
   endtask

   task automatic test_reset_mid();
      exp_t        e;
      logic [65:0] ev;
      @(posedge clk); #1;
      d_bus.valid = 1'b1; d_bus.addr = 32'h8000_3000;
      @(negedge clk);
      checks++;
      if (d_bus.ready !== 1'b1) begin
         errors++;
         $display("FAIL rstmid_accept: got %b expected 1", d_bus.ready);
      end
      @(posedge clk); #1;
      d_bus.valid = 1'b0; m_bus.ready = 1'b0; rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; m_bus.ready = 1'b1; m_bus.rvalid = 1'b1; m_bus.rdata = 32'h0000_5555;
      sb_q.push_back('{NONE, 32'h0000_5555});
      @(negedge clk);
      e  = sb_q.pop_front();
      ev = {e.port == INST, e.port == DATA, (e.port == INST) ? e.data : 32'h0, (e.port == DATA) ? e.data : 32'h0};
      checks++;
      if ({i_bus.rvalid, d_bus.rvalid, i_bus.rdata, d_bus.rdata} !== ev) begin
         errors++;
         $display("FAIL rstmid_drop: got %h expected %h", {i_bus.rvalid, d_bus.rvalid, i_bus.rdata, d_bus.rdata}, ev);
      end
      @(posedge clk); #1;
      m_bus.rvalid = 1'b0; i_bus.valid = 1'b1; i_bus.addr = 32'h8000_0008;
      @(negedge clk);
      checks++;
      if ({i_bus.ready, m_bus.valid, m_bus.addr} !== {1'b1, 1'b1, 32'h8000_0008}) begin
         errors++;
         $display("FAIL rstmid_fetch_req: got %h expected %h", {i_bus.ready, m_bus.valid, m_bus.addr}, {1'b1, 1'b1, 32'h8000_0008});
      end
      sb_q.push_back('{INST, 32'h0000_6666});
      @(posedge clk); #1;
      i_bus.valid = 1'b0; m_bus.rvalid = 1'b1; m_bus.rdata = 32'h0000_6666;
      @(negedge clk);
      e  = sb_q.pop_front();
      ev = {e.port == INST, e.port == DATA, (e.port == INST) ? e.data : 32'h0, (e.port == DATA) ? e.data : 32'h0};
      checks++;
      if ({i_bus.rvalid, d_bus.rvalid, i_bus.rdata, d_bus.rdata} !== ev) begin
         errors++;
         $display("FAIL rstmid_fetch_resp: got %h expected %h", {i_bus.rvalid, d_bus.rvalid, i_bus.rdata, d_bus.rdata}, ev);
      end
      @(posedge clk); #1;
      drive_idle();
   endtask

   initial begin
      test_reset();
      test_single_fetch();
      test_back_to_back();
      test_busy();
      test_stray();
      test_starve();
      test_reset_mid();
      repeat (2) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
